mem_access: RTL and testbench

- Memory stage of the RV32I pipeline, directly downstream of the execute stage.
- Consumes the execute stage's registered instruction and ALU result (the effective address for loads/stores), plus the store data.
- Runs a request/grant/response handshake with the data memory and formats load data.
- Presents a registered instruction/result pair to writeback; back-pressures upstream with stall_o while a memory access is outstanding.

---
 rtl/mem_access.sv | 165 ++++++++++++++++
 tb/tb_mem_access.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// RV32I memory stage: dmem req/gnt/rvalid handshake, load formatting.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] result_o,
  output logic        misalign_o
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] result_q, result_d;
  logic        mis_q, mis_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_ld, is_st, mem_op;
  logic        sz_b, sz_h, sz_w;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] sh;
  logic [31:0] ld_data;

  assign opc    = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign a      = alu_result_i[1:0];
  assign is_ld  = (opc == 7'b0000011);
  assign is_st  = (opc == 7'b0100011);
  assign mem_op = is_ld | is_st;
  assign sz_b   = (f3[1:0] == 2'b00);
  assign sz_h   = (f3[1:0] == 2'b01);
  assign sz_w   = f3[1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = valid_i & mem_op &
               ((sz_h & a[0]) | (sz_w & (a != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wdata = rs2_i;
    unique case (1'b1)
      sz_b: begin
        be    = 4'b0001 << a;
        wdata = {4{rs2_i[7:0]}};
      end
      sz_h: begin
        be    = 4'b0011 << {a[1], 1'b0};
        wdata = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // high bytes shifted in as zero before any extension
  assign sh = dmem_rdata_i >> {a, 3'b000};

  always_comb begin
    ld_data = sh;
    unique case (1'b1)
      sz_b: ld_data = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
      sz_h: ld_data = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    instr_d      = instr_q;
    result_d     = result_q;
    mis_d        = 1'b0;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_be_o    = 4'h0;
    dmem_wdata_o = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && mem_op && !mis) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = is_st;
          dmem_addr_o  = {alu_result_i[31:2], 2'b00};
          dmem_be_o    = be;
          dmem_wdata_o = wdata;
          if (!dmem_gnt_i) begin
            stall_o = 1'b1;
          end else if (is_st) begin
            valid_d  = 1'b1;
            instr_d  = instr_i;
            result_d = alu_result_i;
          end else begin
            stall_o = 1'b1;
            state_d = WAIT;
          end
        end else if (mis) begin
          valid_d  = 1'b1;
          mis_d    = 1'b1;
          instr_d  = instr_i;
          result_d = alu_result_i;
        end else begin
          valid_d  = valid_i;
          instr_d  = instr_i;
          result_d = alu_result_i;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          valid_d  = 1'b1;
          instr_d  = instr_i;
          result_d = ld_data;
          state_d  = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      result_q <= 32'h0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      mis_q    <= mis_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign result_o   = result_q;
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access.
// Honours MEM_MISALIGN_TRAP_EN to pick the misaligned-load expectation.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] result_o;
  logic        misalign_o;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .instr_i      (instr_i),
    .alu_result_i (alu_result_i),
    .rs2_i        (rs2_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .result_o     (result_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [6:0] op);
    return {17'h0, f3, 5'd5, op};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("unexp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr_o", instr_o, e.instr);
        chk("result_o", result_o, e.res);
        chk("misalign_o", {31'h0, misalign_o}, {31'h0, e.mis});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic alu_op(input logic [31:0] res);
    valid_i      = 1'b1;
    instr_i      = mk(3'b000, 7'h33);
    alu_result_i = res;
    dmem_gnt_i   = 1'b0;
    #1;
    chk("pass_stall", {31'h0, stall_o}, 32'd0);
    chk("pass_req", {31'h0, dmem_req_o}, 32'd0);
    sb.push_back('{instr_i, res, 1'b0, cyc + 1});
    @(negedge clk);
  endtask

  task automatic mem_op(input logic [2:0] f3, input logic st,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input int gd, input int rd,
                        input logic [31:0] rdata, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] res);
    valid_i       = 1'b1;
    instr_i       = mk(f3, st ? 7'h23 : 7'h03);
    alu_result_i  = addr;
    rs2_i         = rs2;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    for (int i = 0; i < gd; i++) begin
      #1;
      chk("wait_gnt_req", {31'h0, dmem_req_o}, 32'd1);
      chk("wait_gnt_stall", {31'h0, stall_o}, 32'd1);
      @(negedge clk);
    end
    dmem_gnt_i = 1'b1;
    #1;
    chk("req", {31'h0, dmem_req_o}, 32'd1);
    chk("we", {31'h0, dmem_we_o}, {31'h0, st});
    chk("addr", dmem_addr_o, {addr[31:2], 2'b00});
    chk("be", {28'h0, dmem_be_o}, {28'h0, be});
    if (st) chk("wdata", dmem_wdata_o, wd);
    chk("gnt_stall", {31'h0, stall_o}, {31'h0, ~st});
    if (st) sb.push_back('{instr_i, addr, 1'b0, cyc + 1});
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    if (!st) begin
      for (int j = 0; j < rd; j++) begin
        #1;
        chk("wait_rv_req", {31'h0, dmem_req_o}, 32'd0);
        chk("wait_rv_stall", {31'h0, stall_o}, 32'd1);
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      #1;
      chk("rv_stall", {31'h0, stall_o}, 32'd0);
      sb.push_back('{instr_i, res, 1'b0, cyc + 1});
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    valid_i       = 1'b0;
    instr_i       = 32'h0;
    alu_result_i  = 32'h0;
    rs2_i         = 32'h0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'h0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_mis", {31'h0, misalign_o}, 32'd0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'h0, stall_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    alu_op(32'h0000_1234);
    mem_op(3'b010, 1'b1, 32'h100, 32'hDEADBEEF, 3, 0, 32'h0,
           4'hF, 32'hDEADBEEF, 32'h0);
    mem_op(3'b000, 1'b0, 32'h103, 32'h0, 0, 2, 32'h80FF_0000,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op(3'b100, 1'b0, 32'h103, 32'h0, 1, 2, 32'h80FF_0000,
           4'b1000, 32'h0, 32'h0000_0080);
    mem_op(3'b001, 1'b1, 32'h102, 32'h0000_ABCD, 0, 0, 32'h0,
           4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_op(3'b001, 1'b0, 32'h102, 32'h0, 0, 0, 32'h8001_0000,
           4'b1100, 32'h0, 32'hFFFF_8001);
    mem_op(3'b101, 1'b0, 32'h102, 32'h0, 0, 1, 32'h8001_0000,
           4'b1100, 32'h0, 32'h0000_8001);
    mem_op(3'b000, 1'b1, 32'h201, 32'h0000_005A, 0, 0, 32'h0,
           4'b0010, 32'h5A5A_5A5A, 32'h0);
    alu_op(32'hCAFE_0001);

`ifdef MEM_MISALIGN_TRAP_EN
    valid_i      = 1'b1;
    instr_i      = mk(3'b010, 7'h03);
    alu_result_i = 32'h101;
    #1;
    chk("mis_req", {31'h0, dmem_req_o}, 32'd0);
    chk("mis_stall", {31'h0, stall_o}, 32'd0);
    sb.push_back('{instr_i, 32'h101, 1'b1, cyc + 1});
    @(negedge clk);
`else
    mem_op(3'b010, 1'b0, 32'h101, 32'h0, 0, 0, 32'h1122_3344,
           4'hF, 32'h0, 32'h0011_2233);
`endif

    valid_i      = 1'b0;
    instr_i      = 32'h0;
    alu_result_i = 32'h0;
    repeat (3) @(negedge clk);

    valid_i      = 1'b1;
    instr_i      = mk(3'b010, 7'h03);
    alu_result_i = 32'h200;
    dmem_gnt_i   = 1'b1;
    @(negedge clk);
    dmem_gnt_i   = 1'b0;
    valid_i      = 1'b0;
    instr_i      = 32'h0;
    alu_result_i = 32'h0;
    rst          = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    #1;
    chk("late_rv_stall", {31'h0, stall_o}, 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("late_rv_valid", {31'h0, valid_o}, 32'd0);
    chk("late_rv_result", result_o, 32'd0);
    repeat (2) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
